fft_frame_loader: RTL and testbench

Upstream input stage for the combinational 8-point FFT core `fft_8`. It accepts a stream of complex samples, one per cycle, over a valid/ready handshake. It assembles them into 8-sample frames in a ping-pong pair of banks and presents each completed frame to `fft_8` as packed `[7:0][7:0]` real and imaginary vectors, using a frame-level valid/ready handshake. Double buffering lets it sustain one sample per clock while the downstream stage holds a frame.

---
 rtl/fft_pkg.sv | 28 ++
 rtl/fft_frame_bank.sv | 64 ++++++
 rtl/fft_frame_loader.sv | 136 +++++++++++++
 tb/tb_fft_frame_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// ============================================================================
// Module      : fft_pkg
// Description : Shared constants, sample/frame types and index helpers for
//               the 8-point FFT datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fft_pkg;

    localparam int FFT_N     = 8;
    localparam int FFT_W     = 8;
    localparam int FFT_LOG2N = 3;

    typedef struct packed {
        logic [FFT_W-1:0] re;
        logic [FFT_W-1:0] im;
    } cplx_t;

    typedef logic [FFT_N-1:0][FFT_W-1:0] frame_t;

    function automatic logic [FFT_LOG2N-1:0] bitrev3(input logic [FFT_LOG2N-1:0] k);
        return {k[0], k[1], k[2]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fft_frame_bank.sv
// ============================================================================
// Module      : fft_frame_bank
// Description : One frame buffer: single-slot write, same-cycle zero fill of
//               a slot mask on close, and whole-bank clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_frame_bank #(
    parameter int N  = 8,
    parameter int W  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [IW-1:0]         wr_slot,
    input  logic [W-1:0]          wr_real,
    input  logic [W-1:0]          wr_imag,
    input  logic [N-1:0]          fill_mask,
    input  logic                  close,
    input  logic                  short_in,
    output logic [N-1:0][W-1:0]   frame_real,
    output logic [N-1:0][W-1:0]   frame_imag,
    output logic                  frame_short
);

    logic [N-1:0][W-1:0] r_real;
    logic [N-1:0][W-1:0] r_imag;
    logic                r_short;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_real  <= '0;
            r_imag  <= '0;
            r_short <= 1'b0;
        end else if (clear) begin
            r_real  <= '0;
            r_imag  <= '0;
            r_short <= 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (wr_en && (wr_slot == IW'(k))) begin
                    r_real[k] <= wr_real;
                    r_imag[k] <= wr_imag;
                end else if (fill_mask[k]) begin
                    r_real[k] <= '0;
                    r_imag[k] <= '0;
                end
            end
            if (close) begin
                r_short <= short_in;
            end
        end
    end

    assign frame_real  = r_real;
    assign frame_imag  = r_imag;
    assign frame_short = r_short;

endmodule

`default_nettype wire

// File: rtl/fft_frame_loader.sv
// ============================================================================
// Module      : fft_frame_loader
// Description : Ping-pong frame assembler feeding fft_8. Define
//               FFT_BITREV_LOAD_EN to load samples in bit-reversed slot order.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_frame_loader
    import fft_pkg::*;
#(
    parameter int N = FFT_N,
    parameter int W = FFT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [W-1:0]          in_real,
    input  logic [W-1:0]          in_imag,
    input  logic                  in_last,
    output logic                  frame_valid,
    input  logic                  frame_ready,
    output logic [N-1:0][W-1:0]   out_real,
    output logic [N-1:0][W-1:0]   out_imag,
    output logic                  frame_short
);

    localparam int            IW       = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    logic [1:0]    r_full;
    logic          r_wr_bank;
    logic          r_rd_bank;
    logic [IW-1:0] r_wr_idx;

    logic                w_accept;
    logic                w_consume;
    logic                w_close;
    logic                w_short;
    logic [IW-1:0]       w_slot;
    logic [N-1:0]        w_fill_mask;
    logic [1:0]          w_full_next;
    logic [N-1:0][W-1:0] w_bank_real  [2];
    logic [N-1:0][W-1:0] w_bank_imag  [2];
    logic [1:0]          w_bank_short;

    function automatic logic [IW-1:0] slot_of(input logic [IW-1:0] idx);
`ifdef FFT_BITREV_LOAD_EN
        return bitrev3(idx);
`else
        return idx;
`endif
    endfunction

    assign w_accept  = in_valid && in_ready;
    assign w_consume = frame_valid && frame_ready;
    assign w_close   = w_accept && ((r_wr_idx == LAST_IDX) || in_last);
    assign w_short   = in_last && (r_wr_idx != LAST_IDX);
    assign w_slot    = slot_of(r_wr_idx);

    // Slots belonging to arrival indices not yet received get zeroed on close.
    always_comb begin
        w_fill_mask = '0;
        for (int k = 0; k < N; k++) begin
            if (IW'(k) > r_wr_idx) begin
                w_fill_mask[slot_of(IW'(k))] = 1'b1;
            end
        end
    end

    always_comb begin
        w_full_next = r_full;
        for (int b = 0; b < 2; b++) begin
            if (w_close && (r_wr_bank == 1'(b))) begin
                w_full_next[b] = 1'b1;
            end
            if (w_consume && (r_rd_bank == 1'(b))) begin
                w_full_next[b] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full    <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_idx  <= '0;
        end else begin
            r_full <= w_full_next;
            if (w_accept) begin
                r_wr_idx <= w_close ? '0 : r_wr_idx + 1'b1;
            end
            if (w_close) begin
                r_wr_bank <= ~r_wr_bank;
            end
            if (w_consume) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic w_sel_wr;
        assign w_sel_wr = (r_wr_bank == 1'(b));

        fft_frame_bank #(
            .N (N),
            .W (W)
        ) u_bank (
            .clk         (clk),
            .rst         (rst),
            .clear       (w_consume && (r_rd_bank == 1'(b))),
            .wr_en       (w_accept && w_sel_wr),
            .wr_slot     (w_slot),
            .wr_real     (in_real),
            .wr_imag     (in_imag),
            .fill_mask   ((w_close && w_sel_wr) ? w_fill_mask : '0),
            .close       (w_close && w_sel_wr),
            .short_in    (w_short),
            .frame_real  (w_bank_real[b]),
            .frame_imag  (w_bank_imag[b]),
            .frame_short (w_bank_short[b])
        );
    end

    assign in_ready    = ~r_full[r_wr_bank];
    assign frame_valid = r_full[r_rd_bank];
    assign out_real    = w_bank_real[r_rd_bank];
    assign out_imag    = w_bank_imag[r_rd_bank];
    assign frame_short = w_bank_short[r_rd_bank];

endmodule

`default_nettype wire

// File: tb/tb_fft_frame_loader.sv
// ============================================================================
// Module      : tb_fft_frame_loader
// Description : Directed self-checking bench for fft_frame_loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_frame_loader;

    localparam int N = 8;
    localparam int W = 8;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [W-1:0]        in_real;
    logic [W-1:0]        in_imag;
    logic                in_last;
    logic                frame_valid;
    logic                frame_ready;
    logic [N-1:0][W-1:0] out_real;
    logic [N-1:0][W-1:0] out_imag;
    logic                frame_short;

    int n_checks = 0;
    int n_errors = 0;

    fft_frame_loader #(.N(N), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_real     (in_real),
        .in_imag     (in_imag),
        .in_last     (in_last),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .out_real    (out_real),
        .out_imag    (out_imag),
        .frame_short (frame_short)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int exp_slot(input int k);
        logic [2:0] kk;
        kk = 3'(k);
`ifdef FFT_BITREV_LOAD_EN
        return int'({kk[0], kk[1], kk[2]});
`else
        return int'(kk);
`endif
    endfunction

    // Arrival k carries byte (base + k); unreceived arrivals read as zero.
    function automatic logic [63:0] mk(input int base, input int cnt);
        logic [N-1:0][W-1:0] f;
        f = '0;
        for (int k = 0; k < cnt; k++) begin
            f[exp_slot(k)] = 8'(base + k);
        end
        return f;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int re, input int im, input logic last);
        in_valid = 1'b1;
        in_real  = 8'(re);
        in_imag  = 8'(im);
        in_last  = last;
    endtask

    task automatic idle;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    initial begin
        int accepts;
        int nxt;
        int frames;
        int ready_drops;
        int sum;

        rst = 1'b1; in_valid = 1'b0; in_real = '0; in_imag = '0; in_last = 1'b0;
        frame_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready",    64'(in_ready),    64'd1);
        chk("rst_frame_valid", 64'(frame_valid), 64'd0);
        chk("rst_short",       64'(frame_short), 64'd0);
        chk("rst_out_real",    out_real,         64'd0);
        chk("rst_out_imag",    out_imag,         64'd0);
        rst = 1'b0;
        tick();

        // Basic frame 1..8, imag 0
        frame_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(i + 1, 0, 1'b0);
            tick();
            if (i == 6) chk("t1_valid_early", 64'(frame_valid), 64'd0);
        end
        idle();
        chk("t1_valid",   64'(frame_valid), 64'd1);
        chk("t1_real",    out_real,         mk(1, 8));
        chk("t1_imag",    out_imag,         64'd0);
        chk("t1_short",   64'(frame_short), 64'd0);
        sum = 0;
        for (int k = 0; k < N; k++) sum += int'(out_real[k]);
        chk("t1_bin0_re", 64'(sum), 64'd36);
        tick();
        chk("t1_consumed", 64'(frame_valid), 64'd0);

        // Back-pressure: 20 attempts, 16 accepted
        frame_ready = 1'b0;
        accepts = 0;
        nxt = 1;
        for (int c = 0; c < 20; c++) begin
            drive(nxt, nxt + 100, 1'b0);
            if (in_ready) begin
                accepts++;
                nxt++;
            end
            tick();
            if (c == 9) chk("t2_hold_a", out_real, mk(1, 8));
        end
        chk("t2_accepts",  64'(accepts),     64'd16);
        chk("t2_in_ready", 64'(in_ready),    64'd0);
        chk("t2_hold_b",   out_real,         mk(1, 8));
        chk("t2_imag0",    out_imag,         mk(101, 8));
        idle();
        frame_ready = 1'b1;
        tick();
        chk("t2_f1_real",  out_real,         mk(9, 8));
        chk("t2_f1_imag",  out_imag,         mk(109, 8));
        chk("t2_f1_valid", 64'(frame_valid), 64'd1);
        chk("t2_ready_up", 64'(in_ready),    64'd1);
        tick();
        chk("t2_drained",  64'(frame_valid), 64'd0);

        // Short frame via in_last, then a frame closed normally with last on slot 7
        frame_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(i + 1, 0, i == 2);
            tick();
        end
        idle();
        chk("t3_valid", 64'(frame_valid), 64'd1);
        chk("t3_real",  out_real,         mk(1, 3));
        chk("t3_short", 64'(frame_short), 64'd1);
        frame_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(i + 10, i + 20, i == 7);
            tick();
        end
        idle();
        chk("t3_next_real",  out_real,         mk(10, 8));
        chk("t3_next_imag",  out_imag,         mk(20, 8));
        chk("t3_next_short", 64'(frame_short), 64'd0);
        tick();

        // Continuous 32-sample stream
        frames = 0;
        ready_drops = 0;
        for (int i = 0; i < 32; i++) begin
            drive(i + 1, i + 129, 1'b0);
            if (!in_ready) ready_drops++;
            tick();
            if (frame_valid) begin
                chk($sformatf("t4_f%0d_real", frames), out_real, mk(frames * 8 + 1, 8));
                chk($sformatf("t4_f%0d_imag", frames), out_imag, mk(frames * 8 + 129, 8));
                frames++;
            end
        end
        idle();
        chk("t4_frames",      64'(frames),      64'd4);
        chk("t4_ready_drops", 64'(ready_drops), 64'd0);
        tick();

        // Reset with one FULL bank and a partial frame
        frame_ready = 1'b0;
        for (int i = 0; i < 13; i++) begin
            drive(i + 50, i + 70, 1'b0);
            tick();
        end
        idle();
        chk("t5_pre_valid", 64'(frame_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("t5_in_ready", 64'(in_ready),    64'd1);
        chk("t5_valid",    64'(frame_valid), 64'd0);
        chk("t5_short",    64'(frame_short), 64'd0);
        chk("t5_real",     out_real,         64'd0);
        chk("t5_imag",     out_imag,         64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("t5_post_valid", 64'(frame_valid), 64'd0);
        frame_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(i + 1, 0, 1'b0);
            tick();
        end
        idle();
        chk("t5_clean_valid", 64'(frame_valid), 64'd1);
        chk("t5_clean_real",  out_real,         mk(1, 8));
        chk("t5_clean_short", 64'(frame_short), 64'd0);
        tick();

        // Arrival order 0..7
        for (int i = 0; i < 8; i++) begin
            drive(i, 0, 1'b0);
            tick();
        end
        idle();
`ifdef FFT_BITREV_LOAD_EN
        chk("t6_order", out_real, {8'd7, 8'd3, 8'd5, 8'd1, 8'd6, 8'd2, 8'd4, 8'd0});
`else
        chk("t6_order", out_real, {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0});
`endif
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
